// File: rtl/sram_dp_req_bridge_pkg.sv
// rtl/sram_dp_req_bridge_pkg.sv - shared constants and types for the dual-port SRAM request bridge
package sram_dp_req_bridge_pkg;

  localparam int DEF_ABITS     = 12;
  localparam int DEF_DBITS     = 4;
  localparam int DEF_RSP_DEPTH = 2;

  typedef struct packed {
    logic [DEF_DBITS-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - small synchronous response FIFO with occupancy count
module sram_rsp_fifo
  import sram_dp_req_bridge_pkg::*;
#(
  parameter  int DEPTH = DEF_RSP_DEPTH,
  parameter  int WIDTH = DEF_DBITS,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    do_pop  = pop & (count_q != '0);
    do_push = push & ((count_q != CW'(DEPTH)) | do_pop);
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = ptr_inc(wr_q);
    end
    if (do_pop) begin
      rd_d = ptr_inc(rd_q);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign pop_data = mem_q[rd_q];
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/sram_dp_req_bridge.sv
// rtl/sram_dp_req_bridge.sv - two valid/ready request channels onto a dual-port SRAM,
// read data returned through per-port credit-protected response FIFOs
module sram_dp_req_bridge
  import sram_dp_req_bridge_pkg::*;
#(
  parameter int ABITS     = DEF_ABITS,
  parameter int DBITS     = DEF_DBITS,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             req_valid0,
  output logic             req_ready0,
  input  logic             req_we0,
  input  logic [ABITS-1:0] req_addr0,
  input  logic [DBITS-1:0] req_wdata0,
  output logic             rsp_valid0,
  input  logic             rsp_ready0,
  output logic [DBITS-1:0] rsp_rdata0,
  input  logic             req_valid1,
  output logic             req_ready1,
  input  logic             req_we1,
  input  logic [ABITS-1:0] req_addr1,
  input  logic [DBITS-1:0] req_wdata1,
  output logic             rsp_valid1,
  input  logic             rsp_ready1,
  output logic [DBITS-1:0] rsp_rdata1,
  output logic [ABITS-1:0] A0,
  output logic [DBITS-1:0] D0,
  output logic             WE0,
  output logic             CE0,
  input  logic [DBITS-1:0] Q0,
  output logic [ABITS-1:0] A1,
  output logic [DBITS-1:0] D1,
  output logic             WE1,
  output logic             CE1,
  input  logic [DBITS-1:0] Q1
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic             req_valid [2];
  logic             req_we    [2];
  logic             req_ready [2];
  logic             rsp_valid [2];
  logic             rsp_ready [2];
  logic             fire      [2];
  logic             pop       [2];
  logic             stall     [2];
  logic             fifo_empty[2];
  logic [ABITS-1:0] req_addr  [2];
  logic [DBITS-1:0] q_in      [2];
  logic [DBITS-1:0] rsp_rdata [2];
  logic [CW-1:0]    fifo_count[2];
  logic [CW-1:0]    credits   [2];
  logic [1:0]       inflight_q, inflight_d;

  assign req_valid[0] = req_valid0;
  assign req_valid[1] = req_valid1;
  assign req_we[0]    = req_we0;
  assign req_we[1]    = req_we1;
  assign req_addr[0]  = req_addr0;
  assign req_addr[1]  = req_addr1;
  assign rsp_ready[0] = rsp_ready0;
  assign rsp_ready[1] = rsp_ready1;
  assign q_in[0]      = Q0;
  assign q_in[1]      = Q1;

  always_comb begin
    inflight_d = '0;
    // Port 0 owns the address on a same-cycle collision involving a write.
    stall[0] = 1'b0;
    stall[1] = req_valid[0] & req_valid[1] & (req_addr[0] == req_addr[1]) &
               (req_we[0] | req_we[1]);
    for (int i = 0; i < 2; i++) begin
      rsp_valid[i] = ~fifo_empty[i];
      pop[i]       = rsp_valid[i] & rsp_ready[i];
      // A same-cycle pop frees a slot, which keeps one read per cycle flowing.
      credits[i]   = CW'(inflight_q[i]) + fifo_count[i];
      req_ready[i] = RSTN & ~stall[i] &
                     (req_we[i] | (credits[i] < CW'(RSP_DEPTH)) | pop[i]);
      fire[i]       = req_valid[i] & req_ready[i];
      inflight_d[i] = fire[i] & ~req_we[i];
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_port
    sram_rsp_fifo #(
      .DEPTH(RSP_DEPTH),
      .WIDTH(DBITS)
    ) u_fifo (
      .clk      (CLK),
      .rst_n    (RSTN),
      .push     (inflight_q[i]),
      .push_data(q_in[i]),
      .pop      (pop[i]),
      .pop_data (rsp_rdata[i]),
      .empty    (fifo_empty[i]),
      .count    (fifo_count[i])
    );
  end

  assign req_ready0 = req_ready[0];
  assign req_ready1 = req_ready[1];
  assign rsp_valid0 = rsp_valid[0];
  assign rsp_valid1 = rsp_valid[1];
  assign rsp_rdata0 = rsp_rdata[0];
  assign rsp_rdata1 = rsp_rdata[1];

  assign CE0 = fire[0];
  assign WE0 = fire[0] & req_we0;
  assign A0  = req_addr0;
  assign D0  = req_wdata0;
  assign CE1 = fire[1];
  assign WE1 = fire[1] & req_we1;
  assign A1  = req_addr1;
  assign D1  = req_wdata1;

endmodule

// File: tb/tb_sram_dp_req_bridge.sv
// tb/tb_sram_dp_req_bridge.sv - scoreboard bench for sram_dp_req_bridge with a behavioural dual-port SRAM
module tb_sram_dp_req_bridge;

  localparam int AB = 12;
  localparam int DB = 4;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0;
  logic          req_valid1, req_ready1, req_we1, rsp_valid1, rsp_ready1;
  logic [AB-1:0] req_addr0, req_addr1, A0, A1;
  logic [DB-1:0] req_wdata0, req_wdata1, rsp_rdata0, rsp_rdata1;
  logic [DB-1:0] D0, D1, Q0, Q1;
  logic          WE0, CE0, WE1, CE1;

  always #5 CLK = ~CLK;

  sram_dp_req_bridge #(.ABITS(AB), .DBITS(DB), .RSP_DEPTH(2)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .req_valid0(req_valid0), .req_ready0(req_ready0), .req_we0(req_we0),
    .req_addr0(req_addr0), .req_wdata0(req_wdata0),
    .rsp_valid0(rsp_valid0), .rsp_ready0(rsp_ready0), .rsp_rdata0(rsp_rdata0),
    .req_valid1(req_valid1), .req_ready1(req_ready1), .req_we1(req_we1),
    .req_addr1(req_addr1), .req_wdata1(req_wdata1),
    .rsp_valid1(rsp_valid1), .rsp_ready1(rsp_ready1), .rsp_rdata1(rsp_rdata1),
    .A0(A0), .D0(D0), .WE0(WE0), .CE0(CE0), .Q0(Q0),
    .A1(A1), .D1(D1), .WE1(WE1), .CE1(CE1), .Q1(Q1)
  );

  function automatic logic [DB-1:0] pat(input int a);
    return DB'(a * 3 + 1);
  endfunction

  logic [DB-1:0] mem    [4096];
  logic [DB-1:0] shadow [4096];
  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = pat(i);
      shadow[i] = pat(i);
    end
  end

  // Behavioural SRAM: registered read, one-cycle latency.
  always @(posedge CLK) begin
    if (CE0) begin
      if (WE0) mem[A0] <= D0;
      else     Q0 <= mem[A0];
    end
    if (CE1) begin
      if (WE1) mem[A1] <= D1;
      else     Q1 <= mem[A1];
    end
  end

  typedef struct {
    logic [DB-1:0] d;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t          q0[$], q1[$];
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  int            rsp_cnt0 = 0, rsp_cnt1 = 0;
  logic [DB-1:0] last0, last1;
  bit            lat_chk = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Request side of the scoreboard: record expectations as requests fire.
  always @(negedge CLK) begin
    if (req_valid0 && req_ready0) begin
      if (req_we0) shadow[req_addr0] = req_wdata0;
      else q0.push_back('{d: shadow[req_addr0], cyc: cyc, lat: lat_chk});
    end
    if (req_valid1 && req_ready1) begin
      if (req_we1) shadow[req_addr1] = req_wdata1;
      else q1.push_back('{d: shadow[req_addr1], cyc: cyc, lat: lat_chk});
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (rsp_valid0 && rsp_ready0) begin
      rsp_cnt0++;
      last0 = rsp_rdata0;
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp0_unexpected: got %0h expected none", rsp_rdata0);
      end else begin
        e = q0.pop_front();
        chk("rsp0_data", rsp_rdata0, e.d);
        if (e.lat) chk("rsp0_latency", cyc - e.cyc, 2);
      end
    end
    if (rsp_valid1 && rsp_ready1) begin
      rsp_cnt1++;
      last1 = rsp_rdata1;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp1_unexpected: got %0h expected none", rsp_rdata1);
      end else begin
        e = q1.pop_front();
        chk("rsp1_data", rsp_rdata1, e.d);
        if (e.lat) chk("rsp1_latency", cyc - e.cyc, 2);
      end
    end
  end

  always @(negedge CLK) begin
    if (RSTN) begin
      chk("fifo0_overflow", {31'd0, dut.g_port[0].u_fifo.push && (dut.g_port[0].u_fifo.count_q == 2)
                                    && !dut.g_port[0].u_fifo.pop}, 0);
      chk("fifo1_overflow", {31'd0, dut.g_port[1].u_fifo.push && (dut.g_port[1].u_fifo.count_q == 2)
                                    && !dut.g_port[1].u_fifo.pop}, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int base;
    RSTN = 1'b0;
    req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rsp_valid0", rsp_valid0, 0);
    chk("rst_rsp_valid1", rsp_valid1, 0);
    chk("rst_ce0", CE0, 0);
    chk("rst_we0", WE0, 0);
    chk("rst_ce1", CE1, 0);
    req_valid0 = 1'b0;
    RSTN = 1'b1;

    // Write 0xA to 0x005 on port 0, read it back on port 1 the next cycle.
    lat_chk = 1'b1;
    @(posedge CLK); #1;
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 12'h005; req_wdata0 = 4'hA;
    @(negedge CLK);
    chk("t1_ready0", req_ready0, 1);
    chk("t1_ce0_wr", CE0, 1);
    chk("t1_we0_wr", WE0, 1);
    @(posedge CLK); #1;
    req_valid0 = 1'b0; req_we0 = 1'b0;
    req_valid1 = 1'b1; req_we1 = 1'b0; req_addr1 = 12'h005;
    @(negedge CLK);
    chk("t1_ce0_idle", CE0, 0);
    chk("t1_we0_idle", WE0, 0);
    chk("t1_ce1_rd", CE1, 1);
    chk("t1_we1_rd", WE1, 0);
    @(posedge CLK); #1;
    req_valid1 = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    chk("t1_rdata1", last1, 4'hA);

    // Back-to-back reads 0..7 on port 0.
    base = rsp_cnt0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      req_valid0 = 1'b1; req_addr0 = AB'(i);
      @(negedge CLK);
      chk("t2_ready0", req_ready0, 1);
    end
    @(posedge CLK); #1;
    req_valid0 = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    chk("t2_rsp_count", rsp_cnt0 - base, 8);
    chk("t2_last_rdata0", last0, pat(7));

    // Backpressure: only two reads accepted while rsp_ready0 is low.
    lat_chk = 1'b0;
    rsp_ready0 = 1'b0;
    n_acc = 0;
    base = rsp_cnt0;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      req_valid0 = 1'b1; req_addr0 = AB'(12'h010 + n_acc);
      @(negedge CLK);
      if (req_ready0) n_acc++;
    end
    chk("t3_accepted", n_acc, 2);
    chk("t3_ready_low", req_ready0, 0);
    chk("t3_rsp_pending", rsp_valid0, 1);
    @(posedge CLK); #1;
    req_valid0 = 1'b0;
    rsp_ready0 = 1'b1;
    repeat (4) @(posedge CLK);
    #2;
    chk("t3_drained", rsp_cnt0 - base, 2);
    chk("t3_last_rdata0", last0, pat(12'h011));
    @(posedge CLK); #1;
    req_valid0 = 1'b1; req_addr0 = 12'h012;
    @(negedge CLK);
    chk("t3_resume_ready0", req_ready0, 1);
    @(posedge CLK); #1;
    req_valid0 = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    chk("t3_resume_rdata0", last0, 4'h7);

    // Write/read collision on 0x100: port 1 stalls, then sees the new data.
    lat_chk = 1'b1;
    @(posedge CLK); #1;
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 12'h100; req_wdata0 = 4'h3;
    req_valid1 = 1'b1; req_we1 = 1'b0; req_addr1 = 12'h100;
    @(negedge CLK);
    chk("t4_ready0", req_ready0, 1);
    chk("t4_ready1_stall", req_ready1, 0);
    chk("t4_ce1_stall", CE1, 0);
    @(posedge CLK); #1;
    req_valid0 = 1'b0; req_we0 = 1'b0;
    @(negedge CLK);
    chk("t4_ready1_retry", req_ready1, 1);
    @(posedge CLK); #1;
    req_valid1 = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    chk("t4_rdata1", last1, 4'h3);

    // Read/read on the same address proceeds on both ports.
    @(posedge CLK); #1;
    req_valid0 = 1'b1; req_addr0 = 12'h020;
    req_valid1 = 1'b1; req_addr1 = 12'h020;
    @(negedge CLK);
    chk("t5_ready0", req_ready0, 1);
    chk("t5_ready1", req_ready1, 1);
    @(posedge CLK); #1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    chk("t5_rdata0", last0, 4'h1);
    chk("t5_rdata1", last1, 4'h1);

    // Reset with one read in flight and one queued.
    lat_chk = 1'b0;
    rsp_ready0 = 1'b0;
    @(posedge CLK); #1;
    req_valid0 = 1'b1; req_addr0 = 12'h030;
    @(posedge CLK); #1;
    req_addr0 = 12'h031;
    @(posedge CLK); #1;
    chk("t6_setup_valid", rsp_valid0, 1);
    #2;
    RSTN = 1'b0;
    #1;
    chk("t6_rst_rsp_valid0", rsp_valid0, 0);
    chk("t6_rst_ce0", CE0, 0);
    q0.delete();
    base = rsp_cnt0;
    @(posedge CLK); #2;
    RSTN = 1'b1;
    req_valid0 = 1'b0;
    rsp_ready0 = 1'b1;
    repeat (6) @(posedge CLK);
    #2;
    chk("t6_no_rsp", rsp_cnt0 - base, 0);

    for (int k = 0; k < 20 && (q0.size() + q1.size()) != 0; k++) @(posedge CLK);
    #2;
    chk("sb_empty", q0.size() + q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_dp_req_bridge.md
Name: sram_dp_req_bridge

Overview:
- Initiator side of the dual-port SRAM macro interface (CLK, A0/D0/Q0/WE0/CE0, A1/D1/Q1/WE1/CE1).
- Converts two independent valid/ready request channels into SRAM port strobes.
- Tracks the one-cycle SRAM read latency and returns read data on valid/ready response channels with backpressure.
- Sits between accelerator private-local-memory logic and the technology-mapped SRAM wrappers.

Parameters:
ABITS, 12, SRAM address width
DBITS, 4, SRAM data width
RSP_DEPTH, 2, response FIFO entries per port (min 2)

Ports:
CLK  in  1  clock
RSTN  in  1  asynchronous active-low reset
req_valid0  in  1  port-0 request valid
req_ready0  out  1  port-0 request accepted this cycle
req_we0  in  1  1=write, 0=read
req_addr0  in  ABITS  request address
req_wdata0  in  DBITS  write data
rsp_valid0  out  1  port-0 read data valid
rsp_ready0  in  1  consumer accepts read data
rsp_rdata0  out  DBITS  read data
req_valid1, req_ready1, req_we1, req_addr1, req_wdata1, rsp_valid1, rsp_ready1, rsp_rdata1: same as port 0, for port 1
A0  out  ABITS  SRAM port-0 address
D0  out  DBITS  SRAM port-0 write data
WE0  out  1  SRAM port-0 write enable
CE0  out  1  SRAM port-0 chip enable
Q0  in  DBITS  SRAM port-0 read data
A1, D1, WE1, CE1, Q1: same as port 0, for port 1

Behaviour:
- Reset and clocking:
  - One clock domain (CLK). RSTN is asynchronous, active-low.
  - On reset: FIFOs empty, in-flight flags and credit counters cleared, rsp_valid0/1=0, CE0/1=0, WE0/1=0.
- Request acceptance:
  - fire_x = req_valid_x & req_ready_x.
  - req_ready_x = credit_ok_x & ~stall_x, combinational.
  - credit_ok_x holds when (in-flight read count + FIFO occupancy) < RSP_DEPTH. Writes need no credit, so req_ready_x = ~stall_x for writes.
- SRAM drive:
  - CEx = fire_x; WEx = fire_x & req_we_x; Ax = req_addr_x; Dx = req_wdata_x. All combinational.
  - Ax and Dx are don't-care when CEx=0.
- Read latency:
  - Read fires in cycle k.
  - Qx is valid in cycle k+1 and is pushed into the port FIFO at the end of cycle k+1.
  - rsp_valid_x=1 from cycle k+2.
  - No bypass path. Read-to-response latency is exactly 2 cycles when the FIFO is empty.
- Throughput:
  - With rsp_ready held 1, one read per cycle per port is sustained: 1 in flight + 1 queued = RSP_DEPTH 2.
- Ordering and responses:
  - Responses are in request order per port.
  - Ports are independent. Writes produce no response.
- Cross-port collision (same-cycle, req_addr0 == req_addr1, both req_valid):
  - If either side is a write, stall_1 = 1 and port 0 proceeds.
  - Port 1 retries the next cycle and sees port 0's write.
  - Read/read collisions are not stalled.
- FIFO boundaries:
  - Push and pop in the same cycle on a full FIFO is legal; occupancy is unchanged.
  - A push to a full FIFO cannot occur, because the credit rule prevents it. The bench asserts on any overflow.
- Reset mid-operation:
  - In-flight reads and queued data are discarded.
  - No response is emitted after RSTN deasserts.
- Credit counter width: clog2(RSP_DEPTH+1) bits. It never wraps.

Decomposition:
- Shared package: default ABITS/DBITS constants; a response-entry typedef (DBITS data).
- Sub-module sram_rsp_fifo: RSP_DEPTH-entry synchronous FIFO with count output. Instantiated once per port.
- Top level holds the credit and in-flight logic, the collision stall logic, and the SRAM strobes.

Test Plan:
- Write addr 0x005 data 0xA on port 0, then read 0x005 on port 1 next cycle -> rsp_rdata1=0xA exactly 2 cycles after the read fire; WE0=1, CE0=1 only in the write cycle.
- Back-to-back reads addr 0..7 on port 0 with rsp_ready0=1 -> req_ready0 stays 1, and 8 responses arrive in order on consecutive cycles.
- rsp_ready0=0 while issuing reads -> req_ready0 drops after 2 accepted reads. Raising rsp_ready0 drains 2 responses, then acceptance resumes.
- Same cycle: port 0 writes 0x3 to 0x100 and port 1 reads 0x100 -> req_ready1=0 for that cycle. Port 1's retry returns 0x3.
- Same cycle: both ports read 0x020 -> both accepted, and both return identical data.
- Assert RSTN low with 1 read in flight and 1 queued -> rsp_valid0=0 and CE0=0 immediately. No spurious response after release.
